// File: rtl/serial_paralelo_sync_pkg.sv
// rtl/serial_paralelo_sync_pkg.sv - shared constants and state encoding for the lane deserializer
package serial_paralelo_sync_pkg;

  // Comma/idle symbol, also inserted by the transmit lane serializer
  localparam logic [7:0] COM = 8'hBC;

  // Consecutive aligned commas needed before data is accepted (legal range 1..15)
  localparam int LOCK_COUNT_DEFAULT = 4;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    SYNC   = 2'd1,
    ACTIVE = 2'd2
  } sp_state_e;

endpackage

// File: rtl/sp_align_fsm.sv
// rtl/sp_align_fsm.sv - comma hunt, byte-boundary lock and bit counter realignment
module sp_align_fsm
  import serial_paralelo_sync_pkg::*;
#(
  parameter int LOCK_COUNT = LOCK_COUNT_DEFAULT
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic [7:0] sr_n,
  input  logic [2:0] bit_cnt,
  output logic       boundary,
  output logic       bit_cnt_clr,
  output sp_state_e  state
);

  sp_state_e  state_nx;
  logic [3:0] com_cnt;
  logic [3:0] com_cnt_nx;
  logic       is_com;

  assign is_com = (sr_n == COM);

  // State and comma-count registers
  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) begin
      state   <= SEARCH;
      com_cnt <= 4'd0;
    end else begin
      state   <= state_nx;
      com_cnt <= com_cnt_nx;
    end
  end

  // Next state, comma counting and boundary detection
  always_comb begin
    state_nx    = state;
    com_cnt_nx  = com_cnt;
    boundary    = 1'b0;
    bit_cnt_clr = 1'b0;
    case (state)
      SEARCH: begin
        // Any comma match defines the byte boundary; restart the bit counter here
        if (is_com) begin
          boundary    = 1'b1;
          bit_cnt_clr = 1'b1;
          com_cnt_nx  = 4'd1;
          state_nx    = (LOCK_COUNT == 1) ? ACTIVE : SYNC;
        end
      end
      SYNC: begin
        if (bit_cnt == 3'd7) begin
          boundary = 1'b1;
          if (is_com) begin
            com_cnt_nx = com_cnt + 4'd1;
            if (com_cnt_nx == 4'(LOCK_COUNT)) begin
              state_nx = ACTIVE;
            end
          end else begin
            com_cnt_nx = 4'd0;
            state_nx   = SEARCH;
          end
        end
      end
      ACTIVE: begin
        // Locked for good: no realignment, only reset leaves this state
        boundary = (bit_cnt == 3'd7);
      end
      default: begin
        com_cnt_nx = 4'd0;
        state_nx   = SEARCH;
      end
    endcase
  end

endmodule

// File: rtl/serial_paralelo_sync.sv
// rtl/serial_paralelo_sync.sv - serial-to-parallel lane deserializer with comma alignment (optional SP_BYTE_COUNT_EN)
module serial_paralelo_sync
  import serial_paralelo_sync_pkg::*;
#(
  parameter int LOCK_COUNT = LOCK_COUNT_DEFAULT
) (
  input  logic        clk_32f,
  input  logic        reset,
  input  logic        data_in,
  output logic [7:0]  data_out,
  output logic        valid_out,
  output logic        byte_strobe,
  output logic        active
`ifdef SP_BYTE_COUNT_EN
  ,
  output logic [15:0] rx_bytes
`endif
);

  // Only seven history bits are stored; data_in supplies the eighth of sr_n
  logic [6:0] sr;
  logic [7:0] sr_n;
  logic [2:0] bit_cnt;
  logic       boundary;
  logic       bit_cnt_clr;
  logic       data_take;
  sp_state_e  state;

  assign sr_n      = {sr, data_in};
  assign active    = (state == ACTIVE);
  assign data_take = boundary && (state == ACTIVE) && (sr_n != COM);

  sp_align_fsm #(
    .LOCK_COUNT(LOCK_COUNT)
  ) u_align (
    .clk_32f    (clk_32f),
    .reset      (reset),
    .sr_n       (sr_n),
    .bit_cnt    (bit_cnt),
    .boundary   (boundary),
    .bit_cnt_clr(bit_cnt_clr),
    .state      (state)
  );

  // Serial shift register and position within the byte
  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) begin
      sr      <= '0;
      bit_cnt <= 3'd0;
    end else begin
      sr      <= sr_n[6:0];
      bit_cnt <= bit_cnt_clr ? 3'd0 : bit_cnt + 3'd1;
    end
  end

  // Byte outputs update only at aligned boundaries; commas in ACTIVE are idle
  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) begin
      data_out    <= 8'h00;
      valid_out   <= 1'b0;
      byte_strobe <= 1'b0;
    end else begin
      byte_strobe <= boundary;
      if (boundary && (state == ACTIVE)) begin
        if (sr_n == COM) begin
          valid_out <= 1'b0;
        end else begin
          data_out  <= sr_n;
          valid_out <= 1'b1;
        end
      end
    end
  end

`ifdef SP_BYTE_COUNT_EN
  // Saturating count of data bytes delivered while locked
  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) begin
      rx_bytes <= 16'h0000;
    end else if (data_take && (rx_bytes != 16'hFFFF)) begin
      rx_bytes <= rx_bytes + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_serial_paralelo_sync.sv
// tb/tb_serial_paralelo_sync.sv - scoreboard bench for the lane deserializer
module tb_serial_paralelo_sync;
  import serial_paralelo_sync_pkg::*;

  logic       clk_32f = 1'b0;
  logic       reset;
  logic       data_in;
  logic [7:0] data_out;
  logic       valid_out;
  logic       byte_strobe;
  logic       active;
`ifdef SP_BYTE_COUNT_EN
  logic [15:0] rx_bytes;
`endif

  typedef struct {
    logic [7:0]  data;
    logic        valid;
    logic        act;
    logic [15:0] cnt;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  exp_t mdl;
  int   vectors     = 0;
  int   miscompares = 0;

  serial_paralelo_sync dut (
    .clk_32f    (clk_32f),
    .reset      (reset),
    .data_in    (data_in),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .byte_strobe(byte_strobe),
    .active     (active)
`ifdef SP_BYTE_COUNT_EN
    ,
    .rx_bytes   (rx_bytes)
`endif
  );

  always #5 clk_32f = ~clk_32f;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic observe();
    if (byte_strobe === 1'b1) begin
      vectors++;
      assert (sb.size() != 0) else begin
        miscompares++;
        $error("FAIL unexpected_strobe: got 1 expected 0");
      end
      if (sb.size() != 0) cur = sb.pop_front();
    end
    chk("missed_strobe", 16'(sb.size()), 16'd0);
    chk("data_out", 16'(data_out), 16'(cur.data));
    chk("valid_out", 16'(valid_out), 16'(cur.valid));
    chk("active", 16'(active), 16'(cur.act));
`ifdef SP_BYTE_COUNT_EN
    chk("rx_bytes", rx_bytes, cur.cnt);
`endif
  endtask

  task automatic tick(input logic b, input logic push, input exp_t e);
    @(negedge clk_32f);
    observe();
    data_in = b;
    if (push) sb.push_back(e);
  endtask

  task automatic clear_model();
    mdl.data  = 8'h00;
    mdl.valid = 1'b0;
    mdl.act   = 1'b0;
    mdl.cnt   = 16'h0000;
    cur = mdl;
    sb.delete();
  endtask

  task automatic send(input logic [7:0] b, input logic act_after);
    exp_t e;
    e = mdl;
    if (mdl.act && act_after) begin
      if (b == COM) begin
        e.valid = 1'b0;
      end else begin
        e.data  = b;
        e.valid = 1'b1;
        if (e.cnt != 16'hFFFF) e.cnt = e.cnt + 16'd1;
      end
    end
    e.act = act_after;
    mdl = e;
    for (int i = 7; i >= 1; i--) tick(b[i], 1'b0, e);
    tick(b[0], 1'b1, e);
  endtask

  task automatic pulse_reset(input int cycles);
    reset = 1'b1;
    clear_model();
    for (int i = 0; i < cycles; i++) tick(1'(i), 1'b0, mdl);
    reset = 1'b0;
  endtask

  initial begin
    data_in = 1'b0;
    reset   = 1'b1;
    clear_model();

    // Reset held while data_in toggles: everything stays cleared
    pulse_reset(12);

    // Unaligned lock: 3 random bits, four commas, then two data bytes
    for (int i = 0; i < 3; i++) tick(1'($urandom_range(0, 1)), 1'b0, mdl);
    send(COM, 1'b0);
    send(COM, 1'b0);
    send(COM, 1'b0);
    send(COM, 1'b1);
    send(8'h5A, 1'b1);
    send(8'hC3, 1'b1);

    // Idle comma while locked keeps data_out, drops valid_out
    send(8'h3C, 1'b1);
    send(COM, 1'b1);
    send(8'h7E, 1'b1);

    // Reset three bits into a data byte, checked before the next clock edge
    tick(1'b1, 1'b0, mdl);
    tick(1'b1, 1'b0, mdl);
    tick(1'b1, 1'b0, mdl);
    #2 reset = 1'b1;
    #1;
    chk("async_data_out", 16'(data_out), 16'h0000);
    chk("async_valid_out", 16'(valid_out), 16'h0000);
    chk("async_active", 16'(active), 16'h0000);
    chk("async_strobe", 16'(byte_strobe), 16'h0000);
    pulse_reset(2);
    send(COM, 1'b0);
    send(COM, 1'b0);
    send(COM, 1'b0);
    send(COM, 1'b1);
    send(8'h99, 1'b1);

    // Broken sync: a data byte after two commas sends the aligner back to hunting
    @(negedge clk_32f);
    observe();
    pulse_reset(1);
    send(COM, 1'b0);
    send(COM, 1'b0);
    send(8'h11, 1'b0);
    send(COM, 1'b0);
    send(COM, 1'b0);
    send(COM, 1'b0);
    send(COM, 1'b1);
    send(8'h22, 1'b1);

    // Data bytes mixed with idles for the byte counter
    send(8'h01, 1'b1);
    send(COM, 1'b1);
    send(8'h02, 1'b1);
    send(8'h03, 1'b1);
    send(COM, 1'b1);
    send(8'h04, 1'b1);
    send(8'h05, 1'b1);
    @(negedge clk_32f);
    observe();
    chk("final_data", 16'(data_out), 16'h0005);
`ifdef SP_BYTE_COUNT_EN
    chk("final_rx_bytes", rx_bytes, 16'd6);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
